dram_bus_master: RTL and testbench

//   Synthesisable, parametrised bus master for the simple DRAM/SRAM port (rw/csn/address/data).

---
 rtl/dram_bus_pkg.sv | 28 ++
 rtl/dram_bus_wait_cnt.sv | 45 ++++
 rtl/dram_bus_master.sv | 165 ++++++++++++++++
 tb/tb_dram_bus_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_bus_pkg.sv
// ---------------------------------------------------------------------------
// dram_bus_pkg
//   Shared definitions for the DRAM/SRAM bus master:
//   - FSM state encoding (IDLE / ACCESS / RECOVER)
//   - bus-level constants for rw and csn
//   - width helper for the per-beat wait-state counter
// ---------------------------------------------------------------------------
package dram_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic RW_WRITE     = 1'b0;
    localparam logic RW_READ      = 1'b1;
    localparam logic CSN_ACTIVE   = 1'b0;
    localparam logic CSN_INACTIVE = 1'b1;

    // Counter width for a down-counter that must hold WAIT_CYCLES; never below 1 bit
    function automatic int wait_cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dram_bus_wait_cnt.sv
// ---------------------------------------------------------------------------
// dram_bus_wait_cnt
//   Per-beat wait-state down-counter. Loaded with WAIT_CYCLES at the start of
//   every beat, decremented on tick, and 'last' flags the final cycle of the
//   beat (counter at zero). With WAIT_CYCLES=0 every cycle is a last cycle.
// Ports
//   i_ck   in   clock
//   i_rst  in   synchronous reset, active-high
//   load   in   restart the count for a new beat
//   tick   in   consume one wait cycle
//   last   out  current cycle is the end cycle of the beat
// ---------------------------------------------------------------------------
module dram_bus_wait_cnt
    import dram_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic i_ck,
    input  logic i_rst,
    input  logic load,
    input  logic tick,
    output logic last
);

    localparam int              CW       = wait_cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(WAIT_CYCLES);

    logic [CW-1:0] cnt_r;

    // Wait-state counter: load wins over tick, saturates at zero
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (tick && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/dram_bus_master.sv
// ---------------------------------------------------------------------------
// dram_bus_master
//   Bus master for the simple DRAM/SRAM port (rw/csn/address/data). Accepts
//   one command in IDLE, runs 1..2^BLEN_W beats of WAIT_CYCLES+1 cycles each
//   with csn held low back-to-back, then spends one RECOVER cycle for bus
//   turnaround before returning to IDLE.
// Ports
//   i_ck, i_rst             clock, synchronous active-high reset
//   i_req/i_we/i_addr/i_len command (sampled only in IDLE); i_len = beats-1
//   i_wdata                 write data: beat 0 with i_req, later beats when
//                           o_wdata_rd=1 (combinational strobe)
//   o_ack/o_busy/o_done     command accepted / in progress / finished
//   o_rdata/o_rvalid        read data of last completed read beat + strobe
//   o_rw/o_csn/o_address    memory bus control (registered)
//   o_data/o_data_oe        bus write data and its output enable
//   i_data                  bus read data
// ---------------------------------------------------------------------------
module dram_bus_master
    import dram_bus_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int AWIDTH      = 4,
    parameter int BLEN_W      = 3,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              i_ck,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [BLEN_W-1:0] i_len,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic              o_wdata_rd,
    output logic              o_ack,
    output logic              o_busy,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_done,
    output logic              o_rw,
    output logic              o_csn,
    output logic [AWIDTH-1:0] o_address,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_data_oe,
    input  logic [DWIDTH-1:0] i_data
);

    state_t              state_r;
    logic                we_r;
    logic [BLEN_W-1:0]   len_r;
    logic [BLEN_W-1:0]   beat_r;

    logic                accept_s;
    logic                beat_end_s;
    logic                last_beat_s;
    logic                wait_load_s;
    logic                wait_tick_s;
    logic                wait_last_s;

    assign accept_s    = (state_r == ST_IDLE) && i_req;
    assign beat_end_s  = (state_r == ST_ACCESS) && wait_last_s;
    // beat_r never passes len_r, so len=all-ones completes without overflow
    assign last_beat_s = (beat_r == len_r);
    assign wait_load_s = accept_s || (beat_end_s && !last_beat_s);
    assign wait_tick_s = (state_r == ST_ACCESS) && !wait_last_s;

    // Next write beat's data is taken from i_wdata at this same edge
    assign o_wdata_rd  = beat_end_s && we_r && !last_beat_s;

    dram_bus_wait_cnt #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_cnt (
        .i_ck  (i_ck),
        .i_rst (i_rst),
        .load  (wait_load_s),
        .tick  (wait_tick_s),
        .last  (wait_last_s)
    );

    // Command FSM with all bus and handshake outputs registered
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            we_r      <= 1'b0;
            len_r     <= {BLEN_W{1'b0}};
            beat_r    <= {BLEN_W{1'b0}};
            o_ack     <= 1'b0;
            o_busy    <= 1'b0;
            o_rdata   <= {DWIDTH{1'b0}};
            o_rvalid  <= 1'b0;
            o_done    <= 1'b0;
            o_rw      <= RW_READ;
            o_csn     <= CSN_INACTIVE;
            o_address <= {AWIDTH{1'b0}};
            o_data    <= {DWIDTH{1'b0}};
            o_data_oe <= 1'b0;
        end else begin
            // Pulses default low each cycle
            o_ack    <= 1'b0;
            o_rvalid <= 1'b0;
            o_done   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_req) begin
                        state_r   <= ST_ACCESS;
                        we_r      <= i_we;
                        len_r     <= i_len;
                        beat_r    <= {BLEN_W{1'b0}};
                        o_ack     <= 1'b1;
                        o_busy    <= 1'b1;
                        o_csn     <= CSN_ACTIVE;
                        o_rw      <= i_we ? RW_WRITE : RW_READ;
                        o_address <= i_addr;
                        o_data    <= i_wdata;
                        o_data_oe <= i_we;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (wait_last_s) begin
                        if (!we_r) begin
                            o_rdata  <= i_data;
                            o_rvalid <= 1'b1;
                        end else begin
                            o_rdata  <= o_rdata;
                        end
                        if (!last_beat_s) begin
                            // Back-to-back beat; address wraps at 2^AWIDTH
                            beat_r    <= beat_r + BLEN_W'(1'b1);
                            o_address <= o_address + AWIDTH'(1'b1);
                            if (we_r) begin
                                o_data <= i_wdata;
                            end else begin
                                o_data <= o_data;
                            end
                        end else begin
                            state_r   <= ST_RECOVER;
                            o_csn     <= CSN_INACTIVE;
                            o_rw      <= RW_READ;
                            o_data_oe <= 1'b0;
                            o_address <= {AWIDTH{1'b0}};
                            o_done    <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_RECOVER: begin
                    // One idle bus cycle for turnaround
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    o_busy    <= 1'b0;
                    o_csn     <= CSN_INACTIVE;
                    o_rw      <= RW_READ;
                    o_data_oe <= 1'b0;
                    o_address <= {AWIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_bus_master.sv
// ---------------------------------------------------------------------------
// tb_dram_bus_master
//   Directed bench for dram_bus_master. dut0 runs WAIT_CYCLES=0, dut2 runs
//   WAIT_CYCLES=2. A small memory array answers i_data from o_address.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dram_bus_master;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int BW = 3;

    logic          ck = 1'b0;
    logic          rst;
    logic          req;
    logic          req2;
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] len;
    logic [DW-1:0] wdata;

    logic          d0_wdata_rd, d0_ack, d0_busy, d0_rvalid, d0_done;
    logic          d0_rw, d0_csn, d0_data_oe;
    logic [DW-1:0] d0_rdata, d0_data, d0_idata;
    logic [AW-1:0] d0_address;

    logic          d2_wdata_rd, d2_ack, d2_busy, d2_rvalid, d2_done;
    logic          d2_rw, d2_csn, d2_data_oe;
    logic [DW-1:0] d2_rdata, d2_data, d2_idata;
    logic [AW-1:0] d2_address;

    logic [DW-1:0] mem [0:15];

    int n_cmp = 0;
    int n_err = 0;

    always #5 ck = ~ck;

    assign d0_idata = mem[d0_address];
    assign d2_idata = mem[d2_address];

    dram_bus_master #(.DWIDTH(DW), .AWIDTH(AW), .BLEN_W(BW), .WAIT_CYCLES(0)) u_dut0 (
        .i_ck(ck), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_len(len),
        .i_wdata(wdata), .o_wdata_rd(d0_wdata_rd), .o_ack(d0_ack), .o_busy(d0_busy),
        .o_rdata(d0_rdata), .o_rvalid(d0_rvalid), .o_done(d0_done), .o_rw(d0_rw),
        .o_csn(d0_csn), .o_address(d0_address), .o_data(d0_data),
        .o_data_oe(d0_data_oe), .i_data(d0_idata)
    );

    dram_bus_master #(.DWIDTH(DW), .AWIDTH(AW), .BLEN_W(BW), .WAIT_CYCLES(2)) u_dut2 (
        .i_ck(ck), .i_rst(rst), .i_req(req2), .i_we(we), .i_addr(addr), .i_len(len),
        .i_wdata(wdata), .o_wdata_rd(d2_wdata_rd), .o_ack(d2_ack), .o_busy(d2_busy),
        .o_rdata(d2_rdata), .o_rvalid(d2_rvalid), .o_done(d2_done), .o_rw(d2_rw),
        .o_csn(d2_csn), .o_address(d2_address), .o_data(d2_data),
        .o_data_oe(d2_data_oe), .i_data(d2_idata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge ck);
    endtask

    // Stimulus and checks
    initial begin
        logic [AW-1:0] ea [4];
        logic [DW-1:0] ed [4];
        int seen;
        ea = '{4'hE, 4'hF, 4'h0, 4'h1};
        ed = '{8'h81, 8'h82, 8'h83, 8'h84};

        rst = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0;
        addr = 4'h0; len = 3'd0; wdata = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[7] = 8'h5C; mem[14] = 8'h81; mem[15] = 8'h82; mem[0] = 8'h83; mem[1] = 8'h84;

        // Reset state
        repeat (2) cyc();
        chk("rst_csn",   {31'd0, d0_csn},     32'd1);
        chk("rst_rw",    {31'd0, d0_rw},      32'd1);
        chk("rst_addr",  {28'd0, d0_address}, 32'd0);
        chk("rst_data",  {24'd0, d0_data},    32'd0);
        chk("rst_rdata", {24'd0, d0_rdata},   32'd0);
        chk("rst_oe",    {31'd0, d0_data_oe}, 32'd0);
        chk("rst_ack",   {31'd0, d0_ack},     32'd0);
        chk("rst_busy",  {31'd0, d0_busy},    32'd0);
        chk("rst_rvld",  {31'd0, d0_rvalid},  32'd0);
        chk("rst_done",  {31'd0, d0_done},    32'd0);
        chk("rst_csn2",  {31'd0, d2_csn},     32'd1);
        rst = 1'b0;

        // Single write, WAIT=0
        we = 1'b1; addr = 4'h3; wdata = 8'hA5; len = 3'd0; req = 1'b1;
        cyc();
        chk("sw_ack",  {31'd0, d0_ack},      32'd1);
        chk("sw_busy", {31'd0, d0_busy},     32'd1);
        chk("sw_csn",  {31'd0, d0_csn},      32'd0);
        chk("sw_rw",   {31'd0, d0_rw},       32'd0);
        chk("sw_addr", {28'd0, d0_address},  32'h3);
        chk("sw_data", {24'd0, d0_data},     32'hA5);
        chk("sw_oe",   {31'd0, d0_data_oe},  32'd1);
        chk("sw_wrd",  {31'd0, d0_wdata_rd}, 32'd0);
        req = 1'b0;
        cyc();
        chk("sw_done",  {31'd0, d0_done},    32'd1);
        chk("sw_csn_hi",{31'd0, d0_csn},     32'd1);
        chk("sw_oe_lo", {31'd0, d0_data_oe}, 32'd0);
        chk("sw_addr0", {28'd0, d0_address}, 32'd0);
        chk("sw_rcv_busy", {31'd0, d0_busy}, 32'd1);
        cyc();
        chk("sw_idle_busy", {31'd0, d0_busy}, 32'd0);
        chk("sw_idle_done", {31'd0, d0_done}, 32'd0);

        // Single read, WAIT=2
        we = 1'b0; addr = 4'h7; len = 3'd0; req2 = 1'b1;
        cyc();
        chk("w2_ack",  {31'd0, d2_ack},     32'd1);
        chk("w2_csn",  {31'd0, d2_csn},     32'd0);
        chk("w2_addr", {28'd0, d2_address}, 32'h7);
        chk("w2_rw",   {31'd0, d2_rw},      32'd1);
        chk("w2_oe",   {31'd0, d2_data_oe}, 32'd0);
        req2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("w2_csn_hold", {31'd0, d2_csn},    32'd0);
            chk("w2_ack_lo",   {31'd0, d2_ack},    32'd0);
            chk("w2_rvld_lo",  {31'd0, d2_rvalid}, 32'd0);
        end
        cyc();
        chk("w2_csn_hi", {31'd0, d2_csn},    32'd1);
        chk("w2_rvld",   {31'd0, d2_rvalid}, 32'd1);
        chk("w2_rdata",  {24'd0, d2_rdata},  32'h5C);
        chk("w2_done",   {31'd0, d2_done},   32'd1);
        cyc();
        chk("w2_busy_lo", {31'd0, d2_busy},   32'd0);
        chk("w2_rvld_lo2",{31'd0, d2_rvalid}, 32'd0);

        // Burst read with wrap, plus a second request held while busy
        we = 1'b0; addr = 4'hE; len = 3'd3; req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("br_csn",  {31'd0, d0_csn},      32'd0);
            chk("br_addr", {28'd0, d0_address},  {28'd0, ea[k]});
            chk("br_rw",   {31'd0, d0_rw},       32'd1);
            chk("br_ack",  {31'd0, d0_ack},      (k == 0) ? 32'd1 : 32'd0);
            chk("br_rvld", {31'd0, d0_rvalid},   (k != 0) ? 32'd1 : 32'd0);
            if (k != 0) chk("br_rdata", {24'd0, d0_rdata}, {24'd0, ed[k-1]});
            chk("br_done", {31'd0, d0_done},     32'd0);
            chk("br_wrd",  {31'd0, d0_wdata_rd}, 32'd0);
            if (k == 0) begin
                we = 1'b1; addr = 4'h9; wdata = 8'h3C; len = 3'd0;
            end
        end
        cyc();
        chk("br_csn_hi", {31'd0, d0_csn},     32'd1);
        chk("br_rvld4",  {31'd0, d0_rvalid},  32'd1);
        chk("br_rdata4", {24'd0, d0_rdata},   32'h84);
        chk("br_done1",  {31'd0, d0_done},    32'd1);
        chk("bz_ack_rcv",{31'd0, d0_ack},     32'd0);
        chk("br_busy",   {31'd0, d0_busy},    32'd1);
        cyc();
        chk("bz_idle_busy", {31'd0, d0_busy},   32'd0);
        chk("bz_idle_ack",  {31'd0, d0_ack},    32'd0);
        chk("br_done_once", {31'd0, d0_done},   32'd0);
        chk("br_rvld_end",  {31'd0, d0_rvalid}, 32'd0);
        cyc();
        chk("bz_ack",  {31'd0, d0_ack},     32'd1);
        chk("bz_addr", {28'd0, d0_address}, 32'h9);
        chk("bz_data", {24'd0, d0_data},    32'h3C);
        chk("bz_rw",   {31'd0, d0_rw},      32'd0);
        req = 1'b0;
        cyc();
        chk("bz_done", {31'd0, d0_done}, 32'd1);
        cyc();

        // Burst write len=2
        we = 1'b1; addr = 4'hA; len = 3'd2; wdata = 8'h11; req = 1'b1;
        cyc();
        chk("bw_ack",   {31'd0, d0_ack},      32'd1);
        chk("bw_addr0", {28'd0, d0_address},  32'hA);
        chk("bw_data0", {24'd0, d0_data},     32'h11);
        chk("bw_oe",    {31'd0, d0_data_oe},  32'd1);
        chk("bw_wrd0",  {31'd0, d0_wdata_rd}, 32'd1);
        req = 1'b0; wdata = 8'h22;
        cyc();
        chk("bw_csn1",  {31'd0, d0_csn},      32'd0);
        chk("bw_addr1", {28'd0, d0_address},  32'hB);
        chk("bw_data1", {24'd0, d0_data},     32'h22);
        chk("bw_wrd1",  {31'd0, d0_wdata_rd}, 32'd1);
        wdata = 8'h33;
        cyc();
        chk("bw_csn2",  {31'd0, d0_csn},      32'd0);
        chk("bw_addr2", {28'd0, d0_address},  32'hC);
        chk("bw_data2", {24'd0, d0_data},     32'h33);
        chk("bw_wrd2",  {31'd0, d0_wdata_rd}, 32'd0);
        cyc();
        chk("bw_done",  {31'd0, d0_done},     32'd1);
        chk("bw_csn_hi",{31'd0, d0_csn},      32'd1);
        chk("bw_oe_lo", {31'd0, d0_data_oe},  32'd0);
        cyc();
        chk("bw_idle",  {31'd0, d0_busy},     32'd0);

        // Reset in the middle of an 8-beat write burst
        we = 1'b1; addr = 4'h0; len = 3'd7; wdata = 8'h55; req = 1'b1;
        cyc();
        req = 1'b0;
        chk("mr_oe_pre",   {31'd0, d0_data_oe}, 32'd1);
        chk("mr_busy_pre", {31'd0, d0_busy},    32'd1);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        chk("mr_csn",  {31'd0, d0_csn},     32'd1);
        chk("mr_oe",   {31'd0, d0_data_oe}, 32'd0);
        chk("mr_busy", {31'd0, d0_busy},    32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            cyc();
            if (d0_done || d0_rvalid || !d0_csn) seen++;
        end
        chk("mr_no_tail", seen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
